// File: rtl/rega_arbiter_if.sv
// Request/grant bundle between the requesting datapath units and the rega arbiter.
interface rega_arbiter_if;
    localparam int unsigned N_REQ = 4;

    logic [N_REQ-1:0] req;
    logic             c1;
    logic             c2;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic             busy;
    logic             q_valid;

    modport master (output req, input c1, c2, gnt, ack, busy, q_valid);
    modport slave  (input req, output c1, c2, gnt, ack, busy, q_valid);
endinterface

// File: rtl/rega_arbiter.sv
// Round-robin arbiter for the 4-bit rega select register: grants one requester,
// holds its c1/c2 select for HOLD_CYCLES, then pulses ack and flags q as valid.
module rega_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rega_arbiter_if.slave bus
);
    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {IDLE, SEL, ACK} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               qv_q, qv_d;

    logic [IDX_W-1:0]   idx_c;
    logic [IDX_W-1:0]   pick_c;
    logic               any_c;

    // Rotating priority search; walking downwards lets the nearest set bit win.
    always_comb begin
        idx_c  = ptr_q;
        pick_c = ptr_q;
        any_c  = 1'b0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx_c = ptr_q + IDX_W'(i);
            if (bus.req[idx_c]) begin
                pick_c = idx_c;
                any_c  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        busy_d  = busy_q;
        qv_d    = qv_q;
        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d        = SEL;
                    win_d          = pick_c;
                    gnt_d          = '0;
                    gnt_d[pick_c]  = 1'b1;
                    sel_d          = pick_c;
                    cnt_d          = CNT_W'(HOLD_CYCLES);
                    busy_d         = 1'b1;
                    qv_d           = 1'b0;
                end
            end
            SEL: begin
                cnt_d = cnt_q - CNT_W'(1);
                // A dropped request aborts the grant without advancing the pointer.
                if (!bus.req[win_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    qv_d    = 1'b0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d       = ACK;
                    ack_d[win_q]  = 1'b1;
                    qv_d          = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = win_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // c1/c2 and q_valid deliberately persist through IDLE so rega keeps its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            qv_q    <= qv_d;
        end
    end

    assign bus.c1      = sel_q[1];
    assign bus.c2      = sel_q[0];
    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.q_valid = qv_q;
endmodule

// File: doc/rega_arbiter.md
Name: rega_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-bit `rega` select-register.
- Four requesters (A, B, C, D) compete for the register.
- The arbiter drives the register's `c1`/`c2` source select, grants one requester at a time, and holds the select long enough for the register to capture the data.
- It then pulses a per-requester acknowledge and flags `q` as valid.
- It sits between the requesting datapath units and `rega`.

Parameters:
- HOLD_CYCLES, 1, number of cycles the select is held in SEL before ACK; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request lines: bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive, held until ack.
- c1  output  1  `rega` select MSB, registered.
- c2  output  1  `rega` select LSB, registered.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- ack  output  4  one-cycle acknowledge pulse to the winning requester.
- busy  output  1  high in SEL and ACK.
- q_valid  output  1  `rega` q holds the data of the last acknowledged requester.

Behaviour:
- Reset: rst_n low forces all state and outputs immediately (async):
  - state=IDLE, c1=0, c2=0, gnt=0000, ack=0000, busy=0, q_valid=0, hold counter=0.
  - Round-robin pointer = 0, so A has top priority.
- Select encoding (c1,c2), fixed by `rega`: 00 -> ia (A), 01 -> ib (B), 10 -> ic (C), 11 -> id (D).
- States: IDLE, SEL, ACK.
- IDLE:
  - If req==0000: stay; c1/c2 keep their last value; q_valid keeps its value.
  - If any req bit is set: winner = first set bit searching pointer, pointer+1, ... mod 4.
  - Next edge: gnt=onehot(winner), c1/c2=enc(winner), counter=HOLD_CYCLES, q_valid=0, go to SEL.
- SEL:
  - busy=1. The counter decrements every cycle.
  - `rega` loads on every clk edge with no enable, so the first capture of the selected input happens at the end of the first SEL cycle.
  - When the counter reaches 1 and req[winner] is still high, go to ACK.
- ACK (exactly one cycle):
  - ack[winner]=1, gnt still asserted, q_valid=1, busy=1.
  - Next edge: gnt=0000, ack=0000, pointer=(winner+1) mod 4, go to IDLE.
  - c1/c2 are NOT changed, so `rega` keeps sampling the same source. q_valid stays 1 until the next grant starts.
- Latency: req rising in cycle T (IDLE) -> gnt/select valid at T+1 -> ack at T+1+HOLD_CYCLES. HOLD_CYCLES=1 gives ack at T+2.
- Abort: if req[winner] drops during SEL:
  - Return to IDLE on the next edge.
  - gnt=0, no ack, q_valid=0, pointer unchanged.
- Arbitration only happens in IDLE. New or changing req bits during SEL/ACK are ignored until IDLE.
- A requester still requesting after its ack is treated as a new request. Because the pointer has advanced past it, it gets lowest priority.
- Simultaneous requests: strictly round-robin, so there is no starvation. Worst-case wait is 3 x (HOLD_CYCLES+2) cycles.
- Back-to-back: ACK -> IDLE -> SEL. There is one IDLE cycle between grants, with no gap-skipping.
- Reset mid-SEL/ACK: immediate return to the reset values, and no ack is issued.
- Invariants:
  - gnt is one-hot or zero.
  - ack is a subset of gnt.
  - enc(gnt) == {c1,c2} whenever gnt != 0.

Test Plan:
- Reset then single request: rst_n low 3 cycles, release; req=0001, ia=4'hA, HOLD=1.
  - gnt=0001 and c1c2=00 at T+1.
  - ack=0001 at T+2 with q=4'hA and q_valid=1.
  - gnt=0 at T+3, pointer=1.
- Full contention: req=1111 held, each requester dropping its bit after its own ack.
  - Grant order A, B, C, D.
  - c1c2 sequence 00, 01, 10, 11.
  - q captures ia=1, ib=2, ic=3, id=4 respectively.
  - Exactly one ack per requester.
- Round-robin fairness: after A is acked (pointer=1), req=1001.
  - D is granted next (c1c2=11, ack=1000), not A.
- Abort: HOLD_CYCLES=3, req=0100, drop req[2] in the 2nd SEL cycle.
  - No ack pulse, gnt=0 next cycle, q_valid=0.
  - A later req=0100 is granted again with pointer unchanged.
- Async reset mid-grant: assert rst_n low during ACK, off-edge.
  - gnt, ack, c1, c2, busy and q_valid all go to 0 without waiting for clk.
  - After release, req=0010 gives a grant to B with c1c2=01.
- Requests changing during SEL: req=0001 granted, then req=1110 raised during SEL.
  - Grant stays 0001 through ACK.
  - Next grant is B (pointer=1).
